op_issue: RTL

Front-end command stage for the ALU: synchronises the raw operation button and switch bank, debounces the button, and issues exactly one operation per clean press as a valid/ready transaction carrying the opcode and 8-bit data captured at the press. Sits between the board pins (btnC, sw) and the ALU operation multiplexer, which consumes `op_code`/`op_data` on handshake.

---
 rtl/op_issue_pkg.sv | 29 ++
 rtl/op_issue_if.sv | 13 +
 rtl/bit_sync.sv | 29 ++
 rtl/op_issue.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/op_issue_pkg.sv
// Shared ALU front-end definitions: operand widths, switch field positions
// and the op_issue state encodings.
package op_issue_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int SW_W   = 16;

    // Opcode lives on sw[3:0], the data byte on sw[15:8]; sw[7:4] is spare.
    localparam int SW_OP_LSB   = 0;
    localparam int SW_OP_MSB   = 3;
    localparam int SW_DATA_LSB = 8;
    localparam int SW_DATA_MSB = 15;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PRESS_DB   = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_HELD       = 3'd3;
    localparam logic [2:0] ST_RELEASE_DB = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        PRESS_DB   = ST_PRESS_DB,
        ISSUE      = ST_ISSUE,
        HELD       = ST_HELD,
        RELEASE_DB = ST_RELEASE_DB
    } op_state_e;

endpackage

// File: rtl/op_issue_if.sv
// Valid/ready operation channel from the button front end to the ALU mux.
interface op_issue_if;
    import op_issue_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_code;
    logic [DATA_W-1:0] op_data;

    modport master (output op_valid, output op_code, output op_data, input op_ready);
    modport slave  (input op_valid, input op_code, input op_data, output op_ready);

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for asynchronous board inputs, async active-low reset.
module bit_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/op_issue.sv
// Debounced button-to-operation issuer: one valid/ready transaction per clean press.
// Optional auto-repeat while held is enabled by defining OP_ISSUE_AUTOREPEAT_EN.
module op_issue
    import op_issue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            btn_raw,
    input  logic [SW_W-1:0] sw_raw,
    op_issue_if.master      op,
    output logic            busy
);

    localparam int CNT_SPAN = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_SPAN);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef OP_ISSUE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic            btn_s;
    logic [SW_W-1:0] sw_s;
    logic            sw_unused;

    op_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;
    logic [OP_W-1:0]   code_q;
    logic [DATA_W-1:0] data_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    bit_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_btn_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    bit_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(SW_W)) u_sw_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_s)
    );

    assign sw_unused = ^sw_s[SW_DATA_LSB-1:SW_OP_MSB+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            // Button activity is ignored here; only the ALU can retire the op.
            ISSUE: begin
                if (op.op_ready) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
`ifdef OP_ISSUE_AUTOREPEAT_EN
                else if (cnt_q == RPT_LAST) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
`endif
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                code_q <= sw_s[SW_OP_MSB:SW_OP_LSB];
                data_q <= sw_s[SW_DATA_MSB:SW_DATA_LSB];
            end
        end
    end

    // Valid decodes straight from the state register so reset drops it at once.
    assign op.op_valid = (state_q == ISSUE);
    assign op.op_code  = code_q;
    assign op.op_data  = data_q;
    assign busy        = (state_q != IDLE);

endmodule
